// File: rtl/pacman_pkg.sv
// Shared Pac-Man core definitions: game phase encoding, ghost count and the
// default lives settings also used by the HUD.
// No ports (package).
package pacman_pkg;

  localparam int unsigned NUM_GHOSTS          = 4;
  localparam int unsigned DEFAULT_START_LIVES = 3;
  localparam int unsigned DEFAULT_MAX_LIVES   = 9;
  localparam int unsigned LIVES_W             = 4;
  localparam int unsigned FRAME_CNT_W         = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READY    = 3'd1,
    PLAY     = 3'd2,
    DYING    = 3'd3,
    GAMEOVER = 3'd4
  } game_state_t;

  // Add one life, holding at the ceiling.
  function automatic logic [LIVES_W-1:0] lives_inc(input logic [LIVES_W-1:0] lives,
                                                   input logic [LIVES_W-1:0] ceiling);
    return (lives >= ceiling) ? lives : lives + LIVES_W'(1);
  endfunction

  // Remove one life, holding at zero.
  function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] lives);
    return (lives == '0) ? lives : lives - LIVES_W'(1);
  endfunction

endpackage

// File: rtl/life_sequencer_if.sv
// Game-core <-> life sequencer signal bundle.
//   master: game core side (drives frame/button/collision events, reads status)
//   slave : life_sequencer side
// Events: frame_tick, start, collide, frightened, level_clear, bonus_life.
// Status: livesout, freeze, dying, respawn, ghost_eaten, lost, state.
interface life_sequencer_if;
  import pacman_pkg::*;

  logic                  frame_tick;
  logic                  start;
  logic [NUM_GHOSTS-1:0] collide;
  logic [NUM_GHOSTS-1:0] frightened;
  logic                  level_clear;
  logic                  bonus_life;

  logic [LIVES_W-1:0]    livesout;
  logic                  freeze;
  logic                  dying;
  logic                  respawn;
  logic [NUM_GHOSTS-1:0] ghost_eaten;
  logic                  lost;
  game_state_t           state;

  modport master (
    output frame_tick, start, collide, frightened, level_clear, bonus_life,
    input  livesout, freeze, dying, respawn, ghost_eaten, lost, state
  );

  modport slave (
    input  frame_tick, start, collide, frightened, level_clear, bonus_life,
    output livesout, freeze, dying, respawn, ghost_eaten, lost, state
  );

endinterface

// File: rtl/frame_timer.sv
// Counts frame ticks for a timed phase and strobes done on the tick that
// completes `length` ticks.
//   clk, reset (sync, active-low)
//   clear      : restart counting from zero (phase entry)
//   frame_tick : one-cycle pulse per video frame
//   length     : number of ticks in the phase (>= 1)
//   done       : combinational strobe, high on the final tick
module frame_timer
  import pacman_pkg::*;
#(
  parameter int unsigned Width = FRAME_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic [Width-1:0] length,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] last;

  assign last = length - Width'(1);
  // done must not depend on clear: the owner derives clear from the
  // transition that done itself causes.
  assign done = frame_tick && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (frame_tick) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Round and lives controller: sequences IDLE/READY/PLAY/DYING/GAMEOVER,
// qualifies ghost collisions against frightened status and owns lives.
//   clk, reset (sync, active-low)
//   bus (slave): frame_tick, start, collide, frightened, level_clear,
//                bonus_life in; livesout, freeze, dying, respawn,
//                ghost_eaten, lost, state out.
module life_sequencer
  import pacman_pkg::*;
#(
  parameter int unsigned START_LIVES  = DEFAULT_START_LIVES,
  parameter int unsigned MAX_LIVES    = DEFAULT_MAX_LIVES,
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input logic                 clk,
  input logic                 reset,
  life_sequencer_if.slave     bus
);

  localparam logic [LIVES_W-1:0] StartLives = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] MaxLives   = LIVES_W'(MAX_LIVES);

  game_state_t           state_q, state_d;
  logic [LIVES_W-1:0]    lives_q, lives_d;
  logic                  respawn_q, respawn_d;
  logic [NUM_GHOSTS-1:0] eaten_q, eaten_d;

  logic                   fatal;
  logic [NUM_GHOSTS-1:0]  eaten;
  logic                   timer_clear;
  logic                   timer_done;
  logic [FRAME_CNT_W-1:0] timer_len;

  // A ghost kills Pac-Man unless it is frightened, in which case it is eaten.
  assign fatal = |(bus.collide & ~bus.frightened);
  assign eaten = bus.collide & bus.frightened;

  // Only READY and DYING are timed; one counter serves both.
  assign timer_len   = (state_q == DYING) ? FRAME_CNT_W'(DEATH_FRAMES)
                                          : FRAME_CNT_W'(READY_FRAMES);
  assign timer_clear = (state_d != state_q);

  frame_timer #(
    .Width(FRAME_CNT_W)
  ) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timer_clear),
    .frame_tick (bus.frame_tick),
    .length     (timer_len),
    .done       (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    eaten_d   = '0;

    unique case (state_q)
      IDLE, GAMEOVER: begin
        if (bus.start) begin
          state_d   = READY;
          lives_d   = StartLives;
          respawn_d = 1'b1;
        end
      end

      READY: begin
        if (bus.bonus_life) begin
          lives_d = lives_inc(lives_q, MaxLives);
        end
        if (timer_done) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        eaten_d = eaten;
        if (fatal) begin
          state_d = DYING;
          // A bonus on the fatal edge cancels the loss.
          if (!bus.bonus_life) begin
            lives_d = lives_dec(lives_q);
          end
        end else begin
          if (bus.bonus_life) begin
            lives_d = lives_inc(lives_q, MaxLives);
          end
          if (bus.level_clear) begin
            state_d   = READY;
            respawn_d = 1'b1;
          end
        end
      end

      DYING: begin
        if (bus.bonus_life) begin
          lives_d = lives_inc(lives_q, MaxLives);
        end
        // Exit decision uses the post-bonus count so a last-moment bonus
        // saves the game.
        if (timer_done) begin
          if (lives_d == '0) begin
            state_d = GAMEOVER;
          end else begin
            state_d   = READY;
            respawn_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      lives_q   <= StartLives;
      respawn_q <= 1'b0;
      eaten_q   <= '0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      respawn_q <= respawn_d;
      eaten_q   <= eaten_d;
    end
  end

  assign bus.livesout    = lives_q;
  assign bus.respawn     = respawn_q;
  assign bus.ghost_eaten = eaten_q;
  assign bus.freeze      = (state_q != PLAY);
  assign bus.dying       = (state_q == DYING);
  assign bus.lost        = (state_q == GAMEOVER);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer: directed sequences, a vector
// table in PLAY, and randomized stimulus against a countdown-based model.
module tb_life_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_READY = 1;
  localparam int S_PLAY  = 2;
  localparam int S_DYING = 3;
  localparam int S_OVER  = 4;
  localparam int START_N = 3;
  localparam int MAX_N   = 9;
  localparam int READY_N = 120;
  localparam int DEATH_N = 60;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  life_sequencer_if bus ();

  life_sequencer #(
    .START_LIVES  (START_N),
    .MAX_LIVES    (MAX_N),
    .READY_FRAMES (READY_N),
    .DEATH_FRAMES (DEATH_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start;
    logic       tick;
    logic [3:0] collide;
    logic [3:0] fright;
    logic       lc;
    logic       bonus;
    int         st;
    int         lives;
    logic       resp;
    logic [3:0] eat;
  } vec_t;

  vec_t tbl [8];

  // Behavioural model: phase number, lives and frames remaining in phase.
  int         m_ph;
  int         m_lives;
  int         m_left;
  logic       m_resp;
  logic [3:0] m_eat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start       = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.collide     = 4'b0;
    bus.frightened  = 4'b0;
    bus.level_clear = 1'b0;
    bus.bonus_life  = 1'b0;
  endtask

  task automatic chk_core(input string tag, input int st, input int lives,
                          input logic resp, input logic [3:0] eat);
    chk({tag, ".state"},  32'(bus.state),       st);
    chk({tag, ".lives"},  32'(bus.livesout),    lives);
    chk({tag, ".resp"},   32'(bus.respawn),     32'(resp));
    chk({tag, ".eaten"},  32'(bus.ghost_eaten), 32'(eat));
    chk({tag, ".freeze"}, 32'(bus.freeze),      32'(st != S_PLAY));
    chk({tag, ".dying"},  32'(bus.dying),       32'(st == S_DYING));
    chk({tag, ".lost"},   32'(bus.lost),        32'(st == S_OVER));
  endtask

  task automatic tick_n(input int n);
    bus.frame_tick = 1'b1;
    repeat (n) cyc();
    bus.frame_tick = 1'b0;
  endtask

  // From READY entry with an unstarted count: 119 ticks stay, 120th plays.
  task automatic to_play(input string tag, input int lives);
    tick_n(READY_N - 1);
    chk_core({tag, ".rdy"}, S_READY, lives, 1'b0, 4'b0);
    tick_n(1);
    chk_core({tag, ".play"}, S_PLAY, lives, 1'b0, 4'b0);
  endtask

  task automatic die(input string tag, input int lives_after);
    bus.collide    = 4'b0001;
    bus.frightened = 4'b0000;
    cyc();
    idle_in();
    chk_core(tag, S_DYING, lives_after, 1'b0, 4'b0);
  endtask

  task automatic exit_dying(input string tag, input int exp_st, input int lives);
    tick_n(DEATH_N - 1);
    chk_core({tag, ".dy"}, S_DYING, lives, 1'b0, 4'b0);
    tick_n(1);
    chk_core({tag, ".out"}, exp_st, lives, exp_st == S_READY, 4'b0);
  endtask

  function automatic int inc_sat(input int l);
    return (l >= MAX_N) ? l : l + 1;
  endfunction

  task automatic model_step();
    m_resp = 1'b0;
    m_eat  = 4'b0;
    if (!reset) begin
      m_ph    = S_IDLE;
      m_lives = START_N;
    end else begin
      case (m_ph)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            m_ph = S_READY; m_left = READY_N; m_lives = START_N; m_resp = 1'b1;
          end
        end
        S_READY: begin
          if (bus.bonus_life) m_lives = inc_sat(m_lives);
          if (bus.frame_tick) begin
            m_left--;
            if (m_left == 0) m_ph = S_PLAY;
          end
        end
        S_PLAY: begin
          m_eat = bus.collide & bus.frightened;
          if ((bus.collide & ~bus.frightened) != 4'b0) begin
            if (!bus.bonus_life) m_lives--;
            m_ph = S_DYING; m_left = DEATH_N;
          end else begin
            if (bus.bonus_life) m_lives = inc_sat(m_lives);
            if (bus.level_clear) begin
              m_ph = S_READY; m_left = READY_N; m_resp = 1'b1;
            end
          end
        end
        default: begin
          if (bus.bonus_life) m_lives = inc_sat(m_lives);
          if (bus.frame_tick) begin
            m_left--;
            if (m_left == 0) begin
              if (m_lives == 0) begin
                m_ph = S_OVER;
              end else begin
                m_ph = S_READY; m_left = READY_N; m_resp = 1'b1;
              end
            end
          end
        end
      endcase
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 4'b0100, 4'b0110, 1'b0, 1'b0, S_PLAY,  3, 1'b0, 4'b0100};
    tbl[1] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, S_PLAY,  3, 1'b0, 4'b0000};
    tbl[2] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, S_PLAY,  4, 1'b0, 4'b0000};
    tbl[3] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, S_PLAY,  4, 1'b0, 4'b1111};
    tbl[4] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, S_PLAY,  4, 1'b0, 4'b0000};
    tbl[5] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, S_READY, 4, 1'b1, 4'b0000};
    tbl[6] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, S_READY, 4, 1'b0, 4'b0000};
    tbl[7] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, S_READY, 5, 1'b0, 4'b0000};

    idle_in();
    reset = 1'b0;
    cyc();
    cyc();
    chk_core("rst", S_IDLE, 3, 1'b0, 4'b0);
    reset = 1'b1;
    cyc();
    chk_core("idle", S_IDLE, 3, 1'b0, 4'b0);

    // Start, ready countdown, play.
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_core("start", S_READY, 3, 1'b1, 4'b0);
    cyc();
    chk_core("start1", S_READY, 3, 1'b0, 4'b0);
    to_play("p1", 3);

    // Long-held collision costs one life; held collide ignored while dying.
    bus.collide = 4'b0001;
    cyc();
    chk_core("hit", S_DYING, 2, 1'b0, 4'b0);
    repeat (499) cyc();
    chk_core("hold", S_DYING, 2, 1'b0, 4'b0);
    exit_dying("d1", S_READY, 2);
    idle_in();
    to_play("p2", 2);

    // Fatal + bonus + level_clear together.
    bus.collide     = 4'b0001;
    bus.bonus_life  = 1'b1;
    bus.level_clear = 1'b1;
    cyc();
    idle_in();
    chk_core("combo", S_DYING, 2, 1'b0, 4'b0);
    exit_dying("d2", S_READY, 2);
    to_play("p3", 2);
    die("die2", 1);
    exit_dying("d3", S_READY, 1);
    to_play("p4", 1);
    die("die3", 0);
    exit_dying("d4", S_OVER, 0);

    bus.bonus_life = 1'b1;
    bus.collide    = 4'b1111;
    cyc();
    idle_in();
    chk_core("over_ign", S_OVER, 0, 1'b0, 4'b0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_core("restart", S_READY, 3, 1'b1, 4'b0);
    to_play("p5", 3);

    for (int i = 0; i < 8; i++) begin
      bus.start       = tbl[i].start;
      bus.frame_tick  = tbl[i].tick;
      bus.collide     = tbl[i].collide;
      bus.frightened  = tbl[i].fright;
      bus.level_clear = tbl[i].lc;
      bus.bonus_life  = tbl[i].bonus;
      cyc();
      idle_in();
      chk_core($sformatf("tbl%0d", i), tbl[i].st, tbl[i].lives, tbl[i].resp, tbl[i].eat);
    end
    to_play("p6", 5);

    // Eaten ghost reported even on a fatal cycle; bonus cancels the loss.
    bus.collide    = 4'b0011;
    bus.frightened = 4'b0001;
    bus.bonus_life = 1'b1;
    cyc();
    idle_in();
    chk_core("eat_fatal", S_DYING, 5, 1'b0, 4'b0001);

    bus.bonus_life = 1'b1;
    repeat (4) cyc();
    chk_core("to9", S_DYING, 9, 1'b0, 4'b0);
    cyc();
    bus.bonus_life = 1'b0;
    chk_core("sat9", S_DYING, 9, 1'b0, 4'b0);

    // Reset mid-animation.
    tick_n(30);
    chk_core("dy30", S_DYING, 9, 1'b0, 4'b0);
    reset = 1'b0;
    bus.frame_tick = 1'b1;
    cyc();
    reset = 1'b1;
    idle_in();
    chk_core("rst_mid", S_IDLE, 3, 1'b0, 4'b0);

    // Randomized run against the model.
    reset = 1'b0;
    model_step();
    cyc();
    chk_core("rnd_rst", m_ph, m_lives, m_resp, m_eat);
    reset = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      reset           = ($urandom_range(1999) != 0);
      bus.start       = ($urandom_range(7) == 0);
      bus.frame_tick  = 1'($urandom_range(1));
      bus.collide     = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0;
      bus.frightened  = 4'($urandom);
      bus.level_clear = ($urandom_range(63) == 0);
      bus.bonus_life  = ($urandom_range(399) == 0);
      model_step();
      cyc();
      chk_core("rnd", m_ph, m_lives, m_resp, m_eat);
    end
    reset = 1'b1;
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
